rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
Retire-side consumer of the reorder buffer. The block reads the ROB head entry and commits it in program order. Commit means one of:
- a register-file writeback;
- a data-memory store;
- a load with a memory handshake.

It then pulses `pop` to advance the ROB head. It sits between the ROB read port (commit stage) and the register file / data memory.

Parameters:
XLEN, 32, datapath width (only 32 is supported)
RA_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
head_valid  in  1  ROB head entry is complete and non-empty
head_regWrite  in  1  entry writes rd
head_memWrite  in  1  entry is a store
head_resultSrc  in  2  00 EX result, 01 load data, 10 PC+4, 11 reserved (treated as 00)
head_load  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
head_store  in  2  00 sb, 01 sh, 10 sw
head_rd  in  RA_W  destination register
head_result  in  32  EX result; this is also the memory address for loads and stores
head_wdata  in  32  store data, unaligned in the low bits
head_pc4  in  32  PC+4
pop  out  1  one-cycle pulse: ROB head retired
rf_we  out  1  register-file write enable
rf_wa  out  RA_W  register-file write address
rf_wd  out  32  register-file write data
dmem_req  out  1  memory request; held until ack
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  store data, lane-shifted
dmem_be  out  4  byte enables
dmem_ack  in  1  memory completes the request (1-cycle pulse)
dmem_rdata  in  32  load word, valid when dmem_ack=1

Behaviour:
- FSM states: IDLE, MEM. Registers: state, plus a latched copy of the head entry (lat_*) captured on IDLE->MEM.
- Reset: state=IDLE. All outputs are 0: pop, rf_we, dmem_req, dmem_we, dmem_be, addresses and data. Reset in MEM abandons the request; dmem_req drops the cycle after rst is sampled.
- IDLE, head_valid=0: all outputs 0.
- IDLE, head_valid=1, non-memory entry (memWrite=0 and resultSrc!=01) — combinational same-cycle commit:
  - pop=1;
  - rf_we = head_regWrite & (head_rd!=0);
  - rf_wa = head_rd;
  - rf_wd = head_pc4 if resultSrc=10, else head_result;
  - throughput is 1 commit/cycle.
- IDLE, head_valid=1, memory entry: latch the entry, go to MEM; pop=0 in this cycle.
- MEM:
  - dmem_req=1 (registered, so first asserted the cycle after the head is seen);
  - dmem_we = lat_memWrite;
  - dmem_addr, dmem_be and dmem_wdata are driven from the latch;
  - outputs are stable until ack.
- MEM, on dmem_ack=1 (same cycle):
  - pop=1, state->IDLE, dmem_req=0 on the next cycle.
  - For a load: rf_we = lat_regWrite & (rd!=0), rf_wd = extracted load data.
- IDLE again after MEM: the ROB head has advanced because of pop, so a new entry can be committed immediately.
- Minimum memory-op latency: head seen at cycle N, dmem_req at N+1, ack at N+1 at the earliest, so pop at N+1.
- Byte lanes, with a = addr[1:0]:
  - sb: be = 0001<<a, wdata = {4{wdata[7:0]}}.
  - sh: be = 0011<<(a[1]*2), wdata = {2{wdata[15:0]}}.
  - sw: be = 1111, wdata unchanged.
  - Loads: be=1111. Data is rdata>>(8*a), truncated to 8/16 bits, then sign-extended (lb/lh) or zero-extended (lbu/lhu); lw is passed through.
- Misaligned halfword/word accesses: low address bits below the access size are ignored (sh uses a[1]; sw ignores a).
- dmem_ack while in IDLE: ignored.
- head_valid changes while in MEM: ignored; the latched entry is authoritative.
- Store with head_regWrite=1: no register write.
- Any write with rd=0: rf_we is forced to 0, but pop still occurs.

Optional Feature:
COMMIT_CNT_EN: when defined, adds two outputs:
- instret (64-bit): counts pop pulses, reset to 0, wraps modulo 2^64;
- store_cnt (32-bit): counts committed stores, reset to 0.

When undefined, neither port nor the counter logic exists. Commit behaviour is identical in both builds.

Test Plan:
- ALU entry head_valid=1, rd=5, resultSrc=00, result=0x1234 -> same cycle pop=1, rf_we=1, rf_wa=5, rf_wd=0x1234; back-to-back entries yield one pop per cycle.
- JAL-style entry resultSrc=10, pc4=0x104, rd=1 -> rf_wd=0x104; same entry with rd=0 -> pop=1, rf_we=0.
- Store sb, addr=0x1003, wdata=0xAB -> next cycle dmem_req=1, dmem_we=1, dmem_addr=0x1000, be=1000, wdata=0xABABABAB; ack 3 cycles later -> pop on the ack cycle only, rf_we=0.
- Load lb, addr=0x2002, rdata=0x00800000 on ack -> rf_wd=0xFFFFFF80; lbu gives 0x00000080; lhu at addr=0x2002, rdata=0xBEEF0000 -> 0x0000BEEF.
- Stray dmem_ack in IDLE -> no pop. rst asserted while in MEM -> dmem_req=0 the next cycle, state IDLE, no pop, no rf_we.
- With COMMIT_CNT_EN: 3 ALU commits + 1 store -> instret=4, store_cnt=1; rst -> both 0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// ROB commit stage: retires the head entry in order, as a register writeback, a store, or a handshaked load.
// Optional build macro COMMIT_CNT_EN adds the instret and store_cnt commit counters.
module rob_commit_unit #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            head_valid,
  input  logic            head_regWrite,
  input  logic            head_memWrite,
  input  logic [1:0]      head_resultSrc,
  input  logic [2:0]      head_load,
  input  logic [1:0]      head_store,
  input  logic [RA_W-1:0] head_rd,
  input  logic [XLEN-1:0] head_result,
  input  logic [XLEN-1:0] head_wdata,
  input  logic [XLEN-1:0] head_pc4,
  output logic            pop,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
`ifdef COMMIT_CNT_EN
  ,
  output logic [63:0]     instret,
  output logic [31:0]     store_cnt
`endif
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t state, state_next;

  logic            lat_regWrite;
  logic            lat_memWrite;
  logic [2:0]      lat_load;
  logic [1:0]      lat_store;
  logic [RA_W-1:0] lat_rd;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;

  logic            head_is_mem;
  logic [1:0]      lane;
  logic [3:0]      store_be;
  logic [XLEN-1:0] store_wdata;
  logic [XLEN-1:0] byte_shifted;
  logic [XLEN-1:0] half_shifted;
  logic [XLEN-1:0] load_data;

  assign head_is_mem = head_memWrite | (head_resultSrc == 2'b01);
  assign lane        = lat_addr[1:0];

  // State register plus the entry snapshot taken when a memory op is launched
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_regWrite <= 1'b0;
      lat_memWrite <= 1'b0;
      lat_load     <= '0;
      lat_store    <= '0;
      lat_rd       <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && head_valid && head_is_mem) begin
        lat_regWrite <= head_regWrite;
        lat_memWrite <= head_memWrite;
        lat_load     <= head_load;
        lat_store    <= head_store;
        lat_rd       <= head_rd;
        lat_addr     <= head_result;
        lat_wdata    <= head_wdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (head_valid && head_is_mem) state_next = MEM;
      MEM:  if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte-lane steering; halfword and word accesses ignore the low address bits below their size
  always_comb begin
    unique case (lat_store)
      2'b00: begin
        store_be    = 4'b0001 << lane;
        store_wdata = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        store_be    = lane[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{lat_wdata[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = lat_wdata;
      end
    endcase
  end

  assign byte_shifted = dmem_rdata >> {lane, 3'b000};
  assign half_shifted = dmem_rdata >> {lane[1], 4'b0000};

  always_comb begin
    unique case (lat_load)
      3'b000:  load_data = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
      3'b001:  load_data = {{16{half_shifted[15]}}, half_shifted[15:0]};
      3'b100:  load_data = {24'b0, byte_shifted[7:0]};
      3'b101:  load_data = {16'b0, half_shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  // Reset suppresses any retirement in the cycle it is sampled
  always_comb begin
    pop        = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wd      = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    unique case (state)
      IDLE: begin
        if (head_valid && !head_is_mem) begin
          pop   = 1'b1;
          rf_we = head_regWrite && (head_rd != '0);
          rf_wa = head_rd;
          rf_wd = (head_resultSrc == 2'b10) ? head_pc4 : head_result;
        end
      end
      MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = lat_memWrite;
        dmem_addr  = {lat_addr[XLEN-1:2], 2'b00};
        dmem_be    = lat_memWrite ? store_be : 4'b1111;
        dmem_wdata = lat_memWrite ? store_wdata : '0;
        if (dmem_ack) begin
          pop = 1'b1;
          if (!lat_memWrite) begin
            rf_we = lat_regWrite && (lat_rd != '0);
            rf_wa = lat_rd;
            rf_wd = load_data;
          end
        end
      end
      default: ;
    endcase
    if (rst) begin
      pop   = 1'b0;
      rf_we = 1'b0;
    end
  end

`ifdef COMMIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instret   <= '0;
      store_cnt <= '0;
    end else begin
      if (pop) instret <= instret + 64'd1;
      if (pop && state == MEM && lat_memWrite) store_cnt <= store_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed literal checks plus randomized traffic against a byte-level model.
// Define COMMIT_CNT_EN for the bench as well when building the counter variant.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        head_valid, head_regWrite, head_memWrite;
  logic [1:0]  head_resultSrc;
  logic [2:0]  head_load;
  logic [1:0]  head_store;
  logic [4:0]  head_rd;
  logic [31:0] head_result, head_wdata, head_pc4;
  logic        pop, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
`ifdef COMMIT_CNT_EN
  logic [63:0] instret;
  logic [31:0] store_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rob_commit_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_regWrite(head_regWrite), .head_memWrite(head_memWrite),
    .head_resultSrc(head_resultSrc), .head_load(head_load), .head_store(head_store),
    .head_rd(head_rd), .head_result(head_result), .head_wdata(head_wdata), .head_pc4(head_pc4),
    .pop(pop), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
`ifdef COMMIT_CNT_EN
    , .instret(instret), .store_cnt(store_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit rw, input bit mw, input bit [1:0] src,
                               input bit [2:0] ld, input bit [1:0] st, input bit [4:0] rd,
                               input bit [31:0] res, input bit [31:0] wd, input bit [31:0] pc4,
                               input bit ack, input bit [31:0] rdata, input bit r);
    @(posedge clk);
    #1;
    head_valid = v; head_regWrite = rw; head_memWrite = mw; head_resultSrc = src;
    head_load = ld; head_store = st; head_rd = rd; head_result = res;
    head_wdata = wd; head_pc4 = pc4; dmem_ack = ack; dmem_rdata = rdata; rst = r;
  endtask

  task automatic idleCycle(input bit ack, input bit [31:0] rdata, input bit r);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ack, rdata, r);
  endtask

  // Reference model: a memory access is a contiguous run of 1, 2 or 4 bytes in the addressed word
  function automatic bit [31:0] model_load(bit [2:0] f3, bit [1:0] a, bit [31:0] rdata);
    int size = 1 << f3[1:0];
    int lo = int'(a) & ~(size - 1);
    bit [31:0] v = '0;
    for (int j = 0; j < size; j++) v[8*j +: 8] = rdata[8*(lo+j) +: 8];
    if (!f3[2] && size < 4 && v[8*size-1])
      for (int k = 8*size; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit [3:0] model_be(bit [1:0] st, bit [1:0] a);
    int size = 1 << st;
    int lo = int'(a) & ~(size - 1);
    bit [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + size);
    return be;
  endfunction

  function automatic bit [31:0] model_wdata(bit [1:0] st, bit [31:0] wd);
    int size = 1 << st;
    bit [31:0] v = '0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % size) +: 8];
    return v;
  endfunction

  typedef struct {
    bit        rw, mw;
    bit [2:0]  ld;
    bit [1:0]  st;
    bit [4:0]  rd;
    bit [31:0] addr, wd;
  } entry_t;

  bit        started = 0;
  bit        pend = 0;
  entry_t    p;
  bit [63:0] m_instret = 0;
  bit [31:0] m_store_cnt = 0;

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    bit e_pop, e_we, e_req, e_dwe, is_mem;
    bit [4:0]  e_wa;
    bit [31:0] e_wd, e_addr, e_dwd;
    bit [3:0]  e_be;
    if (rst) begin
      started = 1;
      checkOutput("rst_pop", pop, 0);
      checkOutput("rst_rf_we", rf_we, 0);
      pend = 0;
      m_instret = 0;
      m_store_cnt = 0;
    end else if (started) begin
      e_pop = 0; e_we = 0; e_wa = 0; e_wd = 0;
      e_req = 0; e_dwe = 0; e_addr = 0; e_dwd = 0; e_be = 0;
      is_mem = head_memWrite || (head_resultSrc == 2'b01);
      if (!pend) begin
        if (head_valid && !is_mem) begin
          e_pop = 1;
          e_we = head_regWrite && (head_rd != 0);
          e_wa = head_rd;
          e_wd = (head_resultSrc == 2'b10) ? head_pc4 : head_result;
        end
      end else begin
        e_req = 1;
        e_dwe = p.mw;
        e_addr = p.addr & ~32'd3;
        e_be = p.mw ? model_be(p.st, p.addr[1:0]) : 4'hF;
        if (p.mw) e_dwd = model_wdata(p.st, p.wd);
        if (dmem_ack) begin
          e_pop = 1;
          if (!p.mw) begin
            e_we = p.rw && (p.rd != 0);
            e_wa = p.rd;
            e_wd = model_load(p.ld, p.addr[1:0], dmem_rdata);
          end
        end
      end
      checkOutput("pop", pop, e_pop);
      checkOutput("rf_we", rf_we, e_we);
      if (e_we) begin
        checkOutput("rf_wa", rf_wa, e_wa);
        checkOutput("rf_wd", rf_wd, e_wd);
      end
      checkOutput("dmem_req", dmem_req, e_req);
      checkOutput("dmem_we", dmem_we, e_dwe);
      checkOutput("dmem_addr", dmem_addr, e_addr);
      checkOutput("dmem_be", dmem_be, e_be);
      if (!e_req || e_dwe) checkOutput("dmem_wdata", dmem_wdata, e_dwd);
`ifdef COMMIT_CNT_EN
      checkOutput("instret", instret, m_instret);
      checkOutput("store_cnt", store_cnt, m_store_cnt);
      m_instret += 64'(e_pop);
      if (e_pop && pend && p.mw) m_store_cnt += 1;
`endif
      if (!pend && head_valid && is_mem) begin
        pend = 1;
        p.rw = head_regWrite; p.mw = head_memWrite; p.ld = head_load; p.st = head_store;
        p.rd = head_rd; p.addr = head_result; p.wd = head_wdata;
      end else if (pend && dmem_ack) begin
        pend = 0;
      end
    end
  end

  bit [2:0] lds [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    rst = 1; head_valid = 0; head_regWrite = 0; head_memWrite = 0; head_resultSrc = 0;
    head_load = 0; head_store = 0; head_rd = 0; head_result = 0; head_wdata = 0;
    head_pc4 = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req", dmem_req, 0);
    checkOutput("reset_be", dmem_be, 0);

    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("idle_pop", pop, 0);

    // Same-cycle ALU commits, back to back
    applyStimulus(1, 1, 0, 2'b00, 0, 0, 5, 32'h1234, 0, 0, 0, 0, 0); @(negedge clk);
    checkOutput("alu_pop", pop, 1);
    checkOutput("alu_rf_we", rf_we, 1);
    checkOutput("alu_rf_wa", rf_wa, 5);
    checkOutput("alu_rf_wd", rf_wd, 32'h1234);
    applyStimulus(1, 1, 0, 2'b00, 0, 0, 6, 32'h55, 0, 0, 0, 0, 0); @(negedge clk);
    checkOutput("alu2_pop", pop, 1);
    checkOutput("alu2_rf_wa", rf_wa, 6);

    applyStimulus(1, 1, 0, 2'b10, 0, 0, 1, 32'hDEAD, 0, 32'h104, 0, 0, 0); @(negedge clk);
    checkOutput("jal_rf_wd", rf_wd, 32'h104);
    applyStimulus(1, 1, 0, 2'b10, 0, 0, 0, 32'hDEAD, 0, 32'h104, 0, 0, 0); @(negedge clk);
    checkOutput("jal_rd0_pop", pop, 1);
    checkOutput("jal_rd0_rf_we", rf_we, 0);

    // sb to 0x1003, acked three cycles after the request appears
    applyStimulus(1, 1, 1, 2'b00, 0, 2'b00, 9, 32'h1003, 32'hAB, 0, 0, 0, 0); @(negedge clk);
    checkOutput("sb_seen_pop", pop, 0);
    checkOutput("sb_seen_req", dmem_req, 0);
    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("sb_req", dmem_req, 1);
    checkOutput("sb_we", dmem_we, 1);
    checkOutput("sb_addr", dmem_addr, 32'h1000);
    checkOutput("sb_be", dmem_be, 4'b1000);
    checkOutput("sb_wdata", dmem_wdata, 32'hABABABAB);
    checkOutput("sb_wait_pop", pop, 0);
    repeat (2) begin
      idleCycle(0, 0, 0); @(negedge clk);
      checkOutput("sb_hold_pop", pop, 0);
    end
    idleCycle(1, 0, 0); @(negedge clk);
    checkOutput("sb_ack_pop", pop, 1);
    checkOutput("sb_ack_rf_we", rf_we, 0);
    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("sb_done_req", dmem_req, 0);

    // Loads at 0x2002 with minimum latency
    applyStimulus(1, 1, 0, 2'b01, 3'b000, 0, 3, 32'h2002, 0, 0, 0, 0, 0); @(negedge clk);
    checkOutput("lb_seen_pop", pop, 0);
    idleCycle(1, 32'h00800000, 0); @(negedge clk);
    checkOutput("lb_req", dmem_req, 1);
    checkOutput("lb_addr", dmem_addr, 32'h2000);
    checkOutput("lb_pop", pop, 1);
    checkOutput("lb_rf_wa", rf_wa, 3);
    checkOutput("lb_rf_wd", rf_wd, 32'hFFFFFF80);
    applyStimulus(1, 1, 0, 2'b01, 3'b100, 0, 3, 32'h2002, 0, 0, 0, 0, 0);
    idleCycle(1, 32'h00800000, 0); @(negedge clk);
    checkOutput("lbu_rf_wd", rf_wd, 32'h00000080);
    applyStimulus(1, 1, 0, 2'b01, 3'b101, 0, 4, 32'h2002, 0, 0, 0, 0, 0);
    idleCycle(1, 32'hBEEF0000, 0); @(negedge clk);
    checkOutput("lhu_rf_wd", rf_wd, 32'h0000BEEF);

    idleCycle(1, 32'h12345678, 0); @(negedge clk);
    checkOutput("stray_ack_pop", pop, 0);

    // Reset while a load is outstanding
    applyStimulus(1, 1, 0, 2'b01, 3'b010, 0, 7, 32'h3000, 0, 0, 0, 0, 0);
    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("mem_rst_pre_req", dmem_req, 1);
    idleCycle(1, 32'hCAFE, 1); @(negedge clk);
    checkOutput("mem_rst_pop", pop, 0);
    checkOutput("mem_rst_rf_we", rf_we, 0);
    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("mem_rst_req", dmem_req, 0);
    applyStimulus(1, 1, 0, 2'b00, 0, 0, 2, 32'h77, 0, 0, 0, 0, 0); @(negedge clk);
    checkOutput("post_rst_alu_pop", pop, 1);

`ifdef COMMIT_CNT_EN
    idleCycle(0, 0, 1);
    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("cnt_rst_instret", instret, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 2'b00, 0, 0, 5'(i + 1), 32'(i), 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 2'b00, 0, 2'b10, 0, 32'h40, 32'h1, 0, 0, 0, 0);
    idleCycle(1, 0, 0);
    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("cnt_instret", instret, 4);
    checkOutput("cnt_store", store_cnt, 1);
    idleCycle(0, 0, 1);
    idleCycle(0, 0, 0); @(negedge clk);
    checkOutput("cnt_rst_instret2", instret, 0);
    checkOutput("cnt_rst_store2", store_cnt, 0);
`endif

    // Randomized traffic, including stray acks and occasional resets
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(9) < 7, 1'($urandom), $urandom_range(3) == 0,
                    2'($urandom_range(3)), lds[$urandom_range(4)], 2'($urandom_range(2)),
                    5'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(9) < 3, $urandom, $urandom_range(99) == 0);
    end
    idleCycle(0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
